bug_sprite: RTL

BUG_SPRITE -- requirements
Module: bug_sprite

---
 rtl/bugfest_pkg.sv | 35 +++
 rtl/bug_mover.sv | 96 +++++++++
 rtl/bug_sprite.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/bugfest_pkg.sv
// Shared types, widths and colours for the bug sprite and its mover.
package bugfest_pkg;

    localparam int COORD_W = 15;
    localparam int RGB_W   = 12;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [COORD_W:0]   coord_ext_t;

    typedef enum logic [1:0] {
        ALIVE    = 2'd0,
        SQUASHED = 2'd1,
        RESPAWN  = 2'd2
    } bug_state_t;

    localparam logic [RGB_W-1:0] RGB_ALIVE    = 12'h0F0;
    localparam logic [RGB_W-1:0] RGB_SQUASHED = 12'hF00;
    localparam logic [RGB_W-1:0] RGB_OFF      = 12'h000;

    // Direction flag encodings: 1 means increasing coordinate.
    localparam logic DIR_RIGHT = 1'b1;
    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_DOWN  = 1'b1;
    localparam logic DIR_UP    = 1'b0;

    // True when point (px,py) lies in the square [bx,bx+size) x [by,by+size).
    // One extra bit keeps bx+size from wrapping near the top of the range.
    function automatic logic in_box(input coord_t px, input coord_t py,
                                    input coord_t bx, input coord_t by,
                                    input coord_ext_t size);
        return ({1'b0, px} >= {1'b0, bx}) && ({1'b0, px} < ({1'b0, bx} + size)) &&
               ({1'b0, py} >= {1'b0, by}) && ({1'b0, py} < ({1'b0, by} + size));
    endfunction

endpackage

// File: rtl/bug_mover.sv
// Bug position and direction register with edge bounce.
// move advances one frame step; load puts the bug back at its spawn point.
module bug_mover
    import bugfest_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int SIZE     = 16,
    parameter int SPEED    = 2,
    parameter int X0       = 100,
    parameter int Y0       = 50
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   move,
    input  logic   load,
    output coord_t bug_x,
    output coord_t bug_y
);

    // Largest legal top-left coordinate on each axis.
    localparam coord_ext_t X_MAX = coord_ext_t'(H_ACTIVE - SIZE);
    localparam coord_ext_t Y_MAX = coord_ext_t'(V_ACTIVE - SIZE);
    localparam coord_ext_t SPD   = coord_ext_t'(SPEED);
    localparam coord_t     SPD_C = coord_t'(SPEED);
    localparam coord_t     X0_C  = coord_t'(X0);
    localparam coord_t     Y0_C  = coord_t'(Y0);

    logic   dx;
    logic   dy;
    coord_t next_x;
    coord_t next_y;
    logic   next_dx;
    logic   next_dy;

    // Next position: a step that would reach or cross an edge parks the bug
    // on that edge and reverses it, so coordinates never leave the field.
    always_comb begin
        next_x  = bug_x;
        next_dx = dx;
        if (dx == DIR_RIGHT) begin
            if (({1'b0, bug_x} + SPD) >= X_MAX) begin
                next_x  = X_MAX[COORD_W-1:0];
                next_dx = DIR_LEFT;
            end else begin
                next_x = bug_x + SPD_C;
            end
        end else begin
            if ({1'b0, bug_x} <= SPD) begin
                next_x  = '0;
                next_dx = DIR_RIGHT;
            end else begin
                next_x = bug_x - SPD_C;
            end
        end

        next_y  = bug_y;
        next_dy = dy;
        if (dy == DIR_DOWN) begin
            if (({1'b0, bug_y} + SPD) >= Y_MAX) begin
                next_y  = Y_MAX[COORD_W-1:0];
                next_dy = DIR_UP;
            end else begin
                next_y = bug_y + SPD_C;
            end
        end else begin
            if ({1'b0, bug_y} <= SPD) begin
                next_y  = '0;
                next_dy = DIR_DOWN;
            end else begin
                next_y = bug_y - SPD_C;
            end
        end
    end

    // Position/direction register; respawn reverses horizontal travel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bug_x <= X0_C;
            bug_y <= Y0_C;
            dx    <= DIR_RIGHT;
            dy    <= DIR_DOWN;
        end else if (load) begin
            bug_x <= X0_C;
            bug_y <= Y0_C;
            dx    <= ~dx;
            dy    <= DIR_DOWN;
        end else if (move) begin
            bug_x <= next_x;
            bug_y <= next_y;
            dx    <= next_dx;
            dy    <= next_dy;
        end
    end

endmodule

// File: rtl/bug_sprite.sv
// Bouncing bug sprite: life-cycle FSM, squash detection, score and pixel output.
module bug_sprite
    import bugfest_pkg::*;
#(
    parameter int H_ACTIVE      = 640,
    parameter int V_ACTIVE      = 480,
    parameter int SIZE          = 16,
    parameter int SPEED         = 2,
    parameter int SQUASH_FRAMES = 60,
    parameter int X0            = 100,
    parameter int Y0            = 50
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [14:0] H,
    input  logic [14:0] V,
    input  logic        endFrame,
    input  logic        squash,
    input  logic [14:0] cur_x,
    input  logic [14:0] cur_y,
    output logic        bug_px,
    output logic [11:0] rgb,
    output logic        hit,
    output logic [7:0]  score,
    output logic [14:0] bug_x,
    output logic [14:0] bug_y
);

    // Frame counter needs bit 2 for the blink, so it is at least 3 bits wide.
    localparam int CNT_W = ($clog2(SQUASH_FRAMES + 1) < 3) ? 3 : $clog2(SQUASH_FRAMES + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SQUASH_FRAMES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam coord_ext_t       SIZE_EXT = coord_ext_t'(SIZE);

    logic             rst_meta;
    logic             rst_sync_n;
    bug_state_t       state;
    logic [CNT_W-1:0] frame_cnt;
    logic             squash_hit;
    logic             move;
    logic             load;
    logic             visible;

    // Reset asserts immediately but releases only after two clean clk edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_meta   <= 1'b0;
            rst_sync_n <= 1'b0;
        end else begin
            rst_meta   <= 1'b1;
            rst_sync_n <= rst_meta;
        end
    end

    // A hit is judged on the pre-move position and suppresses that frame's move.
    assign squash_hit = (state == ALIVE) && squash && in_box(cur_x, cur_y, bug_x, bug_y, SIZE_EXT);
    assign move       = (state == ALIVE) && endFrame && !squash_hit;
    assign load       = (state == RESPAWN);

    bug_mover #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .SIZE     (SIZE),
        .SPEED    (SPEED),
        .X0       (X0),
        .Y0       (Y0)
    ) u_mover (
        .clk   (clk),
        .rst_n (rst_sync_n),
        .move  (move),
        .load  (load),
        .bug_x (bug_x),
        .bug_y (bug_y)
    );

    // Visibility: always while alive, blinking every 4 frames while squashed.
    always_comb begin
        visible = 1'b0;
        case (state)
            ALIVE:    visible = 1'b1;
            SQUASHED: visible = ~frame_cnt[2];
            default:  visible = 1'b0;
        endcase
    end

    // Life-cycle FSM with registered hit pulse, saturating score and frame counter.
    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state     <= ALIVE;
            frame_cnt <= '0;
            score     <= 8'd0;
            hit       <= 1'b0;
        end else begin
            hit <= 1'b0;
            unique case (state)
                ALIVE: begin
                    if (squash_hit) begin
                        hit       <= 1'b1;
                        frame_cnt <= '0;
                        state     <= SQUASHED;
                        if (score != 8'hFF) begin
                            score <= score + 8'd1;
                        end
                    end
                end
                SQUASHED: begin
                    if (endFrame) begin
                        frame_cnt <= frame_cnt + CNT_ONE;
                        if (frame_cnt == LAST_CNT) begin
                            state <= RESPAWN;
                        end
                    end
                end
                RESPAWN: begin
                    frame_cnt <= '0;
                    state     <= ALIVE;
                end
                default: begin
                    frame_cnt <= '0;
                    state     <= ALIVE;
                end
            endcase
        end
    end

    // Pixel stage: one clk after H/V, coloured by the life-cycle state.
    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            bug_px <= 1'b0;
            rgb    <= RGB_OFF;
        end else begin
            bug_px <= visible && in_box(H, V, bug_x, bug_y, SIZE_EXT);
            if (visible && in_box(H, V, bug_x, bug_y, SIZE_EXT)) begin
                rgb <= (state == ALIVE) ? RGB_ALIVE : RGB_SQUASHED;
            end else begin
                rgb <= RGB_OFF;
            end
        end
    end

endmodule
